// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types for the clock-gen pearl monitor scheduler.
package bsg_clk_gen_pearl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_e;

    localparam int default_settle_cycles_lp = 8;

endpackage

// File: rtl/bsg_clk_gen_pearl_monitor_edge_det.sv
// Two-flop synchronizer for the asynchronous monitor mux output plus a
// rising-edge detector whose history can be seeded before a measurement.
module bsg_clk_gen_pearl_monitor_edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic monitor_i,
    input  logic seed_i,
    input  logic track_i,
    output logic rise_o
);

    logic sync1_r;
    logic sync2_r;
    logic hist_r;

    // History only follows the synchronized value while seeding or tracking,
    // so an edge that arrives during settle never leaks into the count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= monitor_i;
            sync2_r <= sync1_r;
            if (seed_i || track_i)
                hist_r <= sync2_r;
        end
    end

    assign rise_o = track_i & sync2_r & ~hist_r;

endmodule

// File: rtl/bsg_clk_gen_pearl_monitor_sched.sv
// Round-robin scheduler sharing one edge-counting engine across the
// clock-gen monitor channels; results leave through a valid/yumi handshake.
module bsg_clk_gen_pearl_monitor_sched
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter  int num_clks_p      = 4,
    parameter  int window_width_p  = 16,
    parameter  int count_width_p   = 16,
    parameter  int settle_cycles_p = default_settle_cycles_lp,
    localparam int sel_width_lp    = (num_clks_p > 1) ? $clog2(num_clks_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic [num_clks_p-1:0]     mask_i,
    input  logic [window_width_p-1:0] window_cycles_i,
    input  logic                      monitor_i,
    output logic [sel_width_lp-1:0]   sel_o,
    output logic                      busy_o,
    output logic                      result_v_o,
    output logic [sel_width_lp-1:0]   result_id_o,
    output logic [count_width_p-1:0]  result_count_o,
    input  logic                      result_yumi_i
);

    localparam int                  settle_width_lp = $clog2(settle_cycles_p);
    localparam [settle_width_lp-1:0] settle_load_lp  = settle_width_lp'(settle_cycles_p - 1);

    state_e                      state_r, state_n;
    logic [sel_width_lp-1:0]     sel_r;
    logic [settle_width_lp-1:0]  settle_cnt_r;
    logic [window_width_p-1:0]   win_cnt_r;
    logic [count_width_p-1:0]    edge_cnt_r;
    logic [sel_width_lp-1:0]     result_id_r;
    logic [count_width_p-1:0]    result_count_r;

    logic                        go_w;
    logic                        settle_done_w;
    logic                        win_last_w;
    logic                        rise_w;
    logic [window_width_p-1:0]   win_load_w;
    logic [count_width_p-1:0]    edge_cnt_n;

    // Priority search over the mask rotated to start at cur (or just past it).
    function automatic logic [sel_width_lp-1:0] next_sel(
        input logic [num_clks_p-1:0]   mask,
        input logic [sel_width_lp-1:0] cur,
        input logic                    inclusive
    );
        logic [sel_width_lp-1:0] pick;
        logic                    found;
        int                      idx;
        pick  = cur;
        found = 1'b0;
        for (int i = 0; i < num_clks_p; i++) begin
            idx = int'(cur) + i + (inclusive ? 0 : 1);
            if (idx >= num_clks_p)
                idx = idx - num_clks_p;
            if (!found && mask[idx]) begin
                pick  = sel_width_lp'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign go_w          = en_i && (mask_i != '0);
    assign settle_done_w = (settle_cnt_r == '0);
    assign win_last_w    = (win_cnt_r == window_width_p'(1));
    assign win_load_w    = (window_cycles_i == '0) ? window_width_p'(1) : window_cycles_i;
    assign edge_cnt_n    = (rise_w && (edge_cnt_r != '1)) ? edge_cnt_r + count_width_p'(1)
                                                          : edge_cnt_r;

    bsg_clk_gen_pearl_monitor_edge_det edge_det (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .monitor_i (monitor_i),
        .seed_i    ((state_r == SETTLE) && settle_done_w),
        .track_i   (state_r == MEASURE),
        .rise_o    (rise_w)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_r <= IDLE;
        else
            state_r <= state_n;
    end

    // Dropping en_i wins over window completion: an aborted window yields no result.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (go_w) state_n = SETTLE;
            SETTLE:  if (!en_i) state_n = IDLE;
                     else if (settle_done_w) state_n = MEASURE;
            MEASURE: if (!en_i) state_n = IDLE;
                     else if (win_last_w) state_n = REPORT;
            REPORT:  if (result_yumi_i) state_n = go_w ? SETTLE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_r != IDLE);
        result_v_o     = (state_r == REPORT);
        sel_o          = sel_r;
        result_id_o    = result_id_r;
        result_count_o = result_count_r;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sel_r          <= '0;
            settle_cnt_r   <= '0;
            win_cnt_r      <= '0;
            edge_cnt_r     <= '0;
            result_id_r    <= '0;
            result_count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_w) begin
                        sel_r        <= next_sel(mask_i, sel_r, 1'b1);
                        settle_cnt_r <= settle_load_lp;
                    end
                end
                SETTLE: begin
                    if (en_i) begin
                        if (settle_done_w) begin
                            win_cnt_r  <= win_load_w;
                            edge_cnt_r <= '0;
                        end else begin
                            settle_cnt_r <= settle_cnt_r - settle_width_lp'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (en_i) begin
                        win_cnt_r  <= win_cnt_r - window_width_p'(1);
                        edge_cnt_r <= edge_cnt_n;
                        if (win_last_w) begin
                            result_count_r <= edge_cnt_n;
                            result_id_r    <= sel_r;
                        end
                    end
                end
                REPORT: begin
                    if (result_yumi_i && go_w) begin
                        sel_r        <= next_sel(mask_i, sel_r, 1'b0);
                        settle_cnt_r <= settle_load_lp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bsg_clk_gen_pearl_monitor_sched.md
Name: bsg_clk_gen_pearl_monitor_sched

Overview:
- Reference-clock-domain scheduler that time-shares one frequency-measurement engine across several divided clock-gen monitor outputs.
- Drives the channel select of an external monitor mux. After a settle period, it counts rising edges of the selected monitor signal over a programmable window of reference cycles.
- Reports each result through a valid/yumi handshake, then advances round-robin to the next enabled channel.
- Sits beside the per-oscillator monitors at chip top, feeding the tag/readout path.

Parameters:
- num_clks_p, 4, number of monitor channels (at least 1).
- window_width_p, 16, width of the window-length input.
- count_width_p, 16, width of the edge-count result.
- settle_cycles_p, 8, reference cycles to wait after a select change before measuring (at least 3, to cover the 2-flop synchronizer).

Ports:
- clk_i  in  1  reference clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  scheduler enable.
- mask_i  in  num_clks_p  per-channel enable; bit k=1 means channel k is measured.
- window_cycles_i  in  window_width_p  measurement window length in clk_i cycles.
- monitor_i  in  1  output of the external monitor mux (asynchronous to clk_i).
- sel_o  out  log2(num_clks_p), min 1  channel select to the monitor mux.
- busy_o  out  1  high in any state except IDLE.
- result_v_o  out  1  result valid.
- result_id_o  out  log2(num_clks_p), min 1  channel the result belongs to.
- result_count_o  out  count_width_p  rising edges counted in the window.
- result_yumi_i  in  1  consumer takes the result; legal only while result_v_o=1.

Behaviour:
- Reset (async assert, released synchronously to clk_i) puts all outputs to 0: state=IDLE, sel_o=0, counters=0, synchronizer flops=0.
- monitor_i passes through a 2-flop synchronizer, then a rising-edge detector that compares against the previous synchronized sample.
- FSM states:
  - IDLE: when en_i=1 and mask_i!=0, set sel_o to the first enabled channel at or above the current sel_o (wrapping), load the settle counter, go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: count down settle_cycles_p cycles. Edges are ignored. On expiry, latch the window length into the window counter, clear the edge count, and seed the edge-detector history with the current synchronized value. Go to MEASURE.
    - window_cycles_i=0 is treated as 1.
  - MEASURE: each cycle, decrement the window counter. Increment the edge count on each detected rising edge, saturating at all-ones. In the cycle the window counter reaches 0 (including an edge detected in that cycle), latch result_count_o and result_id_o=sel_o, and go to REPORT.
    - Latency from MEASURE entry to result_v_o is exactly W cycles, where W is the effective window length.
  - REPORT: result_v_o=1, with result_count_o and result_id_o held stable. On result_yumi_i:
    - if en_i=1 and mask_i!=0, set sel_o to the next enabled channel strictly after the current one (wrapping; the same channel if it is the only one enabled) and go to SETTLE;
    - otherwise go to IDLE.
    - No new measurement starts while a result is unconsumed.
- en_i=0 in SETTLE or MEASURE aborts to IDLE the next cycle. No result is produced, and sel_o holds its value.
- mask_i is sampled only at channel selection. Clearing the current channel's bit mid-measurement does not abort the measurement.
- mask_i becoming 0 in REPORT leads to IDLE after yumi.
- sel_o changes only on the IDLE→SETTLE and REPORT→SETTLE transitions. It is stable throughout SETTLE and MEASURE.
- result_yumi_i asserted while result_v_o=0 is ignored.
- Reset mid-measurement: immediate return to the reset state; any partial count is discarded.

Decomposition:
- Shared package bsg_clk_gen_pearl_pkg: state enum (IDLE, SETTLE, MEASURE, REPORT) and the default settle constant.
- Sub-module bsg_clk_gen_pearl_monitor_edge_det: 2-flop synchronizer, history flop, seed input and rising-edge pulse output.
- Round-robin next-channel selection stays inline, as a priority search over the rotated mask.

Test Plan:
- num_clks_p=4, mask=0001, window=600, monitor toggling every 3 clk_i cycles (period 6) → result_id=0, count 100±1; result_v_o rises exactly 600 cycles after MEASURE entry.
- mask=1011, consumer yumis immediately → sel_o/result_id sequence 0,1,3,0,1,3; sel_o stable during each SETTLE+MEASURE; each SETTLE lasts 8 cycles.
- count_width_p=4, window=200, monitor period 4 → result_count_o saturates at 15.
- result_yumi_i held low for 50 cycles in REPORT → result_v_o, result_id_o and result_count_o stable for all 50 cycles; no sel_o change; next SETTLE starts the cycle after yumi.
- en_i dropped midway through MEASURE → IDLE the next cycle, result_v_o never asserts; re-enable → SETTLE on the same sel_o.
- reset_i pulsed asynchronously mid-MEASURE → all outputs 0 immediately; window=0 afterwards → result after 1 MEASURE cycle with count 0 or 1.
